if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage_if.sv | 47 ++++
 rtl/if_fetch_stage_hold_buf.sv | 53 +++++
 rtl/if_fetch_stage.sv | 112 +++++++++++
 tb/tb_if_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, bubble encoding and FSM state type for the instruction fetch stage.
package if_pkg;

  localparam int PC_W    = 22;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  // Word-address increment; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] pcNext(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage signal bundle: pipeline control, instruction memory bus and IF/ID outputs.
// With FETCH_PERF_EN defined the bundle also carries the performance counters.
interface if_fetch_stage_if
  import if_pkg::*;
();

  logic               stall;
  logic               hlt;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rdy;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic [INSTR_W-1:0] instr_IF;
  logic [PC_W-1:0]    PC_IF;
  logic               fetch_valid;

`ifdef FETCH_PERF_EN
  logic [31:0]        perf_bubble_cnt;
  logic [31:0]        perf_discard_cnt;
`endif

  modport master (
    input  stall, hlt, branch_taken, branch_target,
    input  imem_rdy, imem_rvalid, imem_rdata,
    output imem_req, imem_addr,
    output instr_IF, PC_IF, fetch_valid
`ifdef FETCH_PERF_EN
    , output perf_bubble_cnt, perf_discard_cnt
`endif
  );

  modport slave (
    output stall, hlt, branch_taken, branch_target,
    output imem_rdy, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr,
    input  instr_IF, PC_IF, fetch_valid
`ifdef FETCH_PERF_EN
    , input  perf_bubble_cnt, perf_discard_cnt
`endif
  );

endinterface

// File: rtl/if_fetch_stage_hold_buf.sv
// Single-entry instruction/PC holding buffer between the memory response and IF/ID.
module fetch_hold_buf
  import if_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               consume_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  // Flush beats everything; a refill in the same cycle as a consume keeps the new word.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_o = valid_q ? instr_q : NOP_INSTR;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one fetch in flight and buffers the reply.
// Define FETCH_PERF_EN to add saturating bubble and discarded-response counters.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst,
  if_fetch_stage_if.master bus
);

  fetch_state_t       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    reqPc_q;

  logic               consume;
  logic               imemReq;
  logic               accept;
  logic               respLoad;
  logic               bufValid;
  logic [INSTR_W-1:0] bufInstr;
  logic [PC_W-1:0]    bufPc;

  // A new fetch may only start when the buffer will be free at the end of this cycle.
  always_comb begin
    consume  = bufValid & ~bus.stall & ~bus.hlt;
    imemReq  = (state_q == IDLE) & ~rst & ~bus.hlt & ~bus.branch_taken & (~bufValid | consume);
    accept   = imemReq & bus.imem_rdy;
    respLoad = (state_q == WAIT) & bus.imem_rvalid & ~bus.branch_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      reqPc_q <= RESET_PC;
    end else if (bus.branch_taken) begin
      pc_q <= bus.branch_target;
      // A fetch still in flight must be swallowed before the redirect fetch can go out.
      if ((state_q == WAIT || state_q == DISCARD) && !bus.imem_rvalid) begin
        state_q <= DISCARD;
      end else begin
        state_q <= IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= WAIT;
            reqPc_q <= pc_q;
            pc_q    <= pcNext(pc_q);
          end
        end
        WAIT, DISCARD: begin
          if (bus.imem_rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (respLoad),
    .consume_i (consume),
    .flush_i   (bus.branch_taken),
    .instr_i   (bus.imem_rdata),
    .pc_i      (reqPc_q),
    .instr_o   (bufInstr),
    .pc_o      (bufPc),
    .valid_o   (bufValid)
  );

  assign bus.imem_req    = imemReq;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_IF    = bufInstr;
  assign bus.PC_IF       = bufPc;
  assign bus.fetch_valid = bufValid;

`ifdef FETCH_PERF_EN
  logic        respDrop;
  logic [31:0] bubbleCnt_q;
  logic [31:0] discardCnt_q;

  always_comb begin
    respDrop = bus.imem_rvalid & (((state_q == WAIT) & bus.branch_taken) | (state_q == DISCARD));
  end

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCnt_q  <= '0;
      discardCnt_q <= '0;
    end else begin
      if (~bufValid & ~bus.hlt & ~(&bubbleCnt_q)) begin
        bubbleCnt_q <= bubbleCnt_q + 32'd1;
      end
      if (respDrop & ~(&discardCnt_q)) begin
        discardCnt_q <= discardCnt_q + 32'd1;
      end
    end
  end

  assign bus.perf_bubble_cnt  = bubbleCnt_q;
  assign bus.perf_discard_cnt = discardCnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: behavioural memory, scoreboard of expected consumed PCs,
// directed scenarios followed by a randomized run.
module tb_if_fetch_stage;
  import if_pkg::*;

  localparam logic [PC_W-1:0] RESET_PC_TB = '0;

  logic clk = 1'b0;
  logic rst;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (RESET_PC_TB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int fails    = 0;
  int consumed = 0;
  int memLatMin = 1;
  int memLatMax = 1;
  bit memBusy  = 1'b0;

  // Expected program-order PCs of the instructions IF/ID will capture next.
  logic [PC_W-1:0] expQ[$];
  logic [PC_W-1:0] expPc;
  logic [PC_W-1:0] nxtPc;

  function automatic logic [INSTR_W-1:0] memWord(input logic [PC_W-1:0] a);
    return INSTR_W'(a) + 32'h100;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; return mid-cycle once the monitor
  // has sampled, so callers can inspect outputs that depend on this cycle's inputs.
  task automatic applyStimulus(input bit st, input bit hl, input bit br,
                               input logic [PC_W-1:0] tgt, input bit rdy);
    @(posedge clk);
    #1;
    bus.stall         = st;
    bus.hlt           = hl;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.imem_rdy      = rdy;
    @(negedge clk);
    #1;
    if (br) begin
      expQ.delete();
      expQ.push_back(tgt);
    end
  endtask

  task automatic stepIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  // Behavioural instruction memory: one request at a time, reply after memLat cycles.
  initial begin
    logic [PC_W-1:0] a;
    int lat;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.imem_req && bus.imem_rdy) begin
        a   = bus.imem_addr;
        lat = $urandom_range(memLatMax, memLatMin);
        @(posedge clk);
        memBusy = 1'b1;
        repeat (lat - 1) @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memWord(a);
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        memBusy         = 1'b0;
      end
    end
  end

  // Monitor: protocol rules every cycle, and scoreboard comparison on every consume.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.hlt || bus.branch_taken || (bus.fetch_valid && bus.stall))
        checkOutput("reqBlocked", 32'(bus.imem_req), 32'd0);
      if (memBusy)
        checkOutput("oneOutstanding", 32'(bus.imem_req), 32'd0);
      if (!bus.fetch_valid)
        checkOutput("bubbleNop", bus.instr_IF, NOP_INSTR);
      if (bus.fetch_valid && !bus.stall && !bus.hlt) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboardEmpty", 32'd1, 32'd0);
        end else begin
          expPc = expQ.pop_front();
          checkOutput("PC_IF", 32'(bus.PC_IF), 32'(expPc));
          checkOutput("instr_IF", bus.instr_IF, memWord(expPc));
          if (expQ.size() == 0) begin
            nxtPc = expPc + PC_W'(1);
            expQ.push_back(nxtPc);
          end
          consumed++;
        end
      end
    end
  end

  initial begin
    #1000000;
    fails++;
    $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    int n;
    int startCons;
    logic [PC_W-1:0] heldPc;
    logic [INSTR_W-1:0] heldInstr;
    logic [PC_W-1:0] hp;

    rst               = 1'b1;
    bus.stall         = 1'b0;
    bus.hlt           = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.imem_rdy      = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    checkOutput("resetReq", 32'(bus.imem_req), 32'd0);
    checkOutput("resetValid", 32'(bus.fetch_valid), 32'd0);
    checkOutput("resetInstr", bus.instr_IF, NOP_INSTR);
    checkOutput("resetPc", 32'(bus.PC_IF), 32'd0);
`ifdef FETCH_PERF_EN
    checkOutput("resetBubbleCnt", bus.perf_bubble_cnt, 32'd0);
    checkOutput("resetDiscardCnt", bus.perf_discard_cnt, 32'd0);
`endif
    expQ.delete();
    expQ.push_back(RESET_PC_TB);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("firstReq", 32'(bus.imem_req), 32'd1);
    checkOutput("firstAddr", 32'(bus.imem_addr), 32'(RESET_PC_TB));

    // Sequential fetch with 1-cycle memory: one instruction every two cycles
    repeat (6) stepIdle();
    checkOutput("firstThreeConsumed", consumed, 3);
    startCons = consumed;
    repeat (20) stepIdle();
    checkOutput("throughput", consumed - startCons, 10);

    // Stall holds IF/ID inputs and blocks the next fetch until the consume cycle
    n = 0;
    while (bus.fetch_valid && n < 4) begin
      stepIdle();
      n++;
    end
    checkOutput("stallSync", 32'(bus.fetch_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    heldPc    = bus.PC_IF;
    heldInstr = bus.instr_IF;
    checkOutput("stallValid", 32'(bus.fetch_valid), 32'd1);
    checkOutput("stallReq", 32'(bus.imem_req), 32'd0);
    repeat (2) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("stallHoldPc", 32'(bus.PC_IF), 32'(heldPc));
      checkOutput("stallHoldInstr", bus.instr_IF, heldInstr);
      checkOutput("stallReq", 32'(bus.imem_req), 32'd0);
    end
    hp = expQ[0];
    stepIdle();
    checkOutput("stallReleaseReq", 32'(bus.imem_req), 32'd1);
    checkOutput("stallReleaseAddr", 32'(bus.imem_addr), 32'(hp + PC_W'(1)));

    // Branch while waiting; response arrives two cycles after the redirect and is dropped
    memLatMin = 3;
    memLatMax = 3;
    n = 0;
    do begin
      stepIdle();
      n++;
    end while (!(bus.imem_req && bus.imem_rdy) && n < 8);
    checkOutput("acceptSeen", 32'(bus.imem_req && bus.imem_rdy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 22'h2A, 1'b1);
    n = 0;
    do begin
      stepIdle();
      n++;
      checkOutput("discardNoValid", 32'(bus.fetch_valid), 32'd0);
    end while (!bus.imem_req && n < 8);
    checkOutput("redirectDelay", n, 3);
    checkOutput("redirectAddr", 32'(bus.imem_addr), 32'h2A);
`ifdef FETCH_PERF_EN
    checkOutput("discardCnt", bus.perf_discard_cnt, 32'd1);
`endif

    // Branch coinciding with the response; redirect target exercises PC wrap-around
    memLatMin = 1;
    memLatMax = 1;
    n = 0;
    do begin
      stepIdle();
      n++;
    end while (!(bus.imem_req && bus.imem_rdy) && n < 8);
    checkOutput("acceptSeen2", 32'(bus.imem_req && bus.imem_rdy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 22'h3FFFFF, 1'b1);
    stepIdle();
    checkOutput("sameCycleDropValid", 32'(bus.fetch_valid), 32'd0);
    checkOutput("sameCycleReq", 32'(bus.imem_req), 32'd1);
    checkOutput("sameCycleAddr", 32'(bus.imem_addr), 32'h3FFFFF);
    stepIdle();
    stepIdle();
    checkOutput("wrapPc", 32'(bus.PC_IF), 32'h3FFFFF);
    checkOutput("wrapReq", 32'(bus.imem_req), 32'd1);
    checkOutput("wrapAddr", 32'(bus.imem_addr), 32'h0);

    // Halt with a fetch outstanding: the word lands and is held, fetching resumes on release
    memLatMin = 2;
    memLatMax = 2;
    n = 0;
    do begin
      stepIdle();
      n++;
    end while (!(bus.imem_req && bus.imem_rdy) && n < 8);
    checkOutput("acceptSeen3", 32'(bus.imem_req && bus.imem_rdy), 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
    checkOutput("hltHeldValid", 32'(bus.fetch_valid), 32'd1);
    checkOutput("hltHeldPc", 32'(bus.PC_IF), 32'(expQ[0]));
    hp = expQ[0];
    stepIdle();
    checkOutput("hltResumeReq", 32'(bus.imem_req), 32'd1);
    checkOutput("hltResumeAddr", 32'(bus.imem_addr), 32'(hp + PC_W'(1)));

    // Randomized traffic against the scoreboard
    memLatMin = 1;
    memLatMax = 4;
    startCons = consumed;
    for (int i = 0; i < 2000; i++) begin
      bit st;
      bit hl;
      bit br;
      bit rd;
      logic [PC_W-1:0] tgt;
      st  = ($urandom_range(99, 0) < 25);
      hl  = ($urandom_range(99, 0) < 8);
      br  = ($urandom_range(99, 0) < 4);
      rd  = ($urandom_range(99, 0) < 70);
      tgt = ($urandom_range(3, 0) == 0) ? 22'h3FFFFE : PC_W'($urandom);
      applyStimulus(st, hl, br, tgt, rd);
    end
    repeat (12) stepIdle();
    checkOutput("randomProgress", 32'(consumed - startCons >= 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
